// File: rtl/wb_stage_buffered.sv
// Writeback stage: forms the register-file write value from the ALU or memory result,
// queues it in an in-order DEPTH-entry buffer, drains one write per cycle over a
// valid/ack port, and offers a youngest-match lookup of pending writes.
module wb_stage_buffered #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 3,
   parameter int unsigned DEPTH     = 2,
   parameter bit          ZERO_DROP = 1'b0
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic                           flush_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic                           in_reg_write_i,
   input  logic                           in_sel_mem_i,
   input  logic [1:0]                     in_ld_mode_i,
   input  logic [DATA_W-1:0]              in_alu_i,
   input  logic [DATA_W-1:0]              in_mem_i,
   input  logic [ADDR_W-1:0]              in_rd_i,
   output logic                           wr_en_o,
   output logic [ADDR_W-1:0]              wr_addr_o,
   output logic [DATA_W-1:0]              wr_data_o,
   input  logic                           wr_ack_i,
   input  logic [ADDR_W-1:0]              q_addr_i,
   output logic                           q_hit_o,
   output logic [DATA_W-1:0]              q_data_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [CntW-1:0]   count_q, count_d;

   logic              push;
   logic              pop;
   logic [DATA_W-1:0] src;
   logic [DATA_W+15:0] src_wide;
   logic [7:0]        lo_byte;
   logic [7:0]        hi_byte;
   logic [DATA_W-1:0] wdata;

   // Ready and head outputs come from registered state only.
   assign in_ready_o = (count_q < CntW'(DEPTH));
   assign wr_en_o    = (count_q != '0);
   assign wr_addr_o  = wr_en_o ? addr_q[rptr_q] : '0;
   assign wr_data_o  = wr_en_o ? data_q[rptr_q] : '0;
   assign count_o    = count_q;

   assign push = in_valid_i && in_ready_o && in_reg_write_i &&
                 !(ZERO_DROP && (in_rd_i == '0));
   assign pop  = wr_en_o && wr_ack_i;

   // Zero-padded copy so the high byte is well defined for narrow datapaths.
   assign src      = in_sel_mem_i ? in_mem_i : in_alu_i;
   assign src_wide = {16'h0000, src};
   assign lo_byte  = src[7:0];
   assign hi_byte  = src_wide[15:8];

   // Write-value formation: load extension applies to memory data only.
   always_comb begin
      wdata = src;
      if (in_sel_mem_i) begin
         case (in_ld_mode_i)
            2'b01:   wdata = DATA_W'(lo_byte);
            2'b10:   wdata = DATA_W'($signed(lo_byte));
            2'b11:   wdata = DATA_W'(hi_byte);
            default: wdata = src;
         endcase
      end
   end

   // Next-state for buffer, pointers and count; flush overrides push and pop.
   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            addr_d[wptr_q] = in_rd_i;
            data_d[wptr_q] = wdata;
            wptr_d         = wptr_q + PtrW'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CntW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Lookup: scan oldest to youngest so the youngest valid match is kept last.
   always_comb begin
      logic [PtrW-1:0] idx;
      idx      = '0;
      q_hit_o  = 1'b0;
      q_data_o = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = rptr_q + PtrW'(k);
         if ((CntW'(k) < count_q) && (addr_q[idx] == q_addr_i)) begin
            q_hit_o  = 1'b1;
            q_data_o = data_q[idx];
         end
      end
   end

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Bench for wb_stage_buffered: two instances (ZERO_DROP 0 and 1) share stimulus and are
// compared against a list-based model of the pending writes.
module tb_wb_stage_buffered;

   localparam int DW  = 16;
   localparam int AW  = 3;
   localparam int DEP = 2;

   logic          clk = 1'b0;
   logic          reset_n, flush, in_valid, in_reg_write, in_sel_mem, wr_ack;
   logic [1:0]    in_ld_mode;
   logic [DW-1:0] in_alu, in_mem;
   logic [AW-1:0] in_rd, q_addr;

   logic          rdy [2];
   logic          wen [2];
   logic          qhit [2];
   logic [AW-1:0] waddr [2];
   logic [DW-1:0] wdata [2];
   logic [DW-1:0] qdata [2];
   logic [1:0]    cnt [2];

   int checks = 0;
   int errors = 0;

   // Model: index 0 is the oldest pending write.
   int            m_cnt [2];
   logic [AW-1:0] m_addr [2][DEP];
   logic [DW-1:0] m_data [2][DEP];

   always #5 clk = ~clk;

   wb_stage_buffered #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .ZERO_DROP(1'b0)) dut0 (
      .clk_i(clk), .reset_ni(reset_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(rdy[0]), .in_reg_write_i(in_reg_write), .in_sel_mem_i(in_sel_mem),
      .in_ld_mode_i(in_ld_mode), .in_alu_i(in_alu), .in_mem_i(in_mem), .in_rd_i(in_rd),
      .wr_en_o(wen[0]), .wr_addr_o(waddr[0]), .wr_data_o(wdata[0]), .wr_ack_i(wr_ack),
      .q_addr_i(q_addr), .q_hit_o(qhit[0]), .q_data_o(qdata[0]), .count_o(cnt[0])
   );

   wb_stage_buffered #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .ZERO_DROP(1'b1)) dut1 (
      .clk_i(clk), .reset_ni(reset_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(rdy[1]), .in_reg_write_i(in_reg_write), .in_sel_mem_i(in_sel_mem),
      .in_ld_mode_i(in_ld_mode), .in_alu_i(in_alu), .in_mem_i(in_mem), .in_rd_i(in_rd),
      .wr_en_o(wen[1]), .wr_addr_o(waddr[1]), .wr_data_o(wdata[1]), .wr_ack_i(wr_ack),
      .q_addr_i(q_addr), .q_hit_o(qhit[1]), .q_data_o(qdata[1]), .count_o(cnt[1])
   );

   function automatic logic [DW-1:0] exp_data(input logic sel, input logic [1:0] mode,
                                              input logic [DW-1:0] alu,
                                              input logic [DW-1:0] mem);
      if (!sel) return alu;
      case (mode)
         2'b01:   return mem & 16'h00FF;
         2'b10:   return (mem & 16'h00FF) | (mem[7] ? 16'hFF00 : 16'h0000);
         2'b11:   return (mem >> 8) & 16'h00FF;
         default: return mem;
      endcase
   endfunction

   task automatic model_update(input int i, input bit zd);
      bit ready, pop, push;
      if (!reset_n || flush) begin
         m_cnt[i] = 0;
         return;
      end
      ready = (m_cnt[i] < DEP);
      pop   = (m_cnt[i] > 0) && wr_ack;
      push  = in_valid && ready && in_reg_write && !(zd && in_rd == 0);
      if (pop) begin
         for (int k = 0; k < DEP - 1; k++) begin
            m_addr[i][k] = m_addr[i][k+1];
            m_data[i][k] = m_data[i][k+1];
         end
         m_cnt[i]--;
      end
      if (push) begin
         m_addr[i][m_cnt[i]] = in_rd;
         m_data[i][m_cnt[i]] = exp_data(in_sel_mem, in_ld_mode, in_alu, in_mem);
         m_cnt[i]++;
      end
   endtask

   // One clock: advance the model with the inputs present at the edge.
   task automatic tick();
      model_update(0, 1'b0);
      model_update(1, 1'b1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      flush = 0; in_valid = 0; in_reg_write = 1; in_sel_mem = 0; in_ld_mode = 2'b00;
      in_alu = '0; in_mem = '0; in_rd = '0; wr_ack = 0; q_addr = '0;
   endtask

   task automatic set_push(input logic [AW-1:0] rd, input logic [DW-1:0] d);
      in_valid = 1; in_reg_write = 1; in_sel_mem = 0; in_rd = rd; in_alu = d;
   endtask

   task automatic test_reset();
      reset_n = 0; idle();
      set_push(3'd5, 16'hBEEF);
      wr_ack = 1;
      tick(); tick();
      in_valid = 0; q_addr = 3'd5; #1;
      for (int i = 0; i < 2; i++) begin
         checks += 7;
         if (wen[i] !== 1'b0) begin errors++; $display("FAIL reset_wen dut%0d got %b want 0", i, wen[i]); end
         if (waddr[i] !== '0) begin errors++; $display("FAIL reset_waddr dut%0d got %h want 0", i, waddr[i]); end
         if (wdata[i] !== '0) begin errors++; $display("FAIL reset_wdata dut%0d got %h want 0", i, wdata[i]); end
         if (qhit[i] !== 1'b0) begin errors++; $display("FAIL reset_qhit dut%0d got %b want 0", i, qhit[i]); end
         if (qdata[i] !== '0) begin errors++; $display("FAIL reset_qdata dut%0d got %h want 0", i, qdata[i]); end
         if (cnt[i] !== 2'd0) begin errors++; $display("FAIL reset_count dut%0d got %0d want 0", i, cnt[i]); end
         if (rdy[i] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got %b want 1", i, rdy[i]); end
      end
      reset_n = 1;
      tick();
   endtask

   task automatic test_alu_write();
      idle();
      set_push(3'd3, 16'h1234);
      wr_ack = 1;
      tick();
      in_valid = 0;
      for (int i = 0; i < 2; i++) begin
         checks += 4;
         if (wen[i] !== 1'b1) begin errors++; $display("FAIL alu_wen dut%0d got %b want 1", i, wen[i]); end
         if (waddr[i] !== 3'd3) begin errors++; $display("FAIL alu_waddr dut%0d got %h want 3", i, waddr[i]); end
         if (wdata[i] !== 16'h1234) begin errors++; $display("FAIL alu_wdata dut%0d got %h want 1234", i, wdata[i]); end
         if (cnt[i] !== 2'd1) begin errors++; $display("FAIL alu_count dut%0d got %0d want 1", i, cnt[i]); end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         checks += 2;
         if (cnt[i] !== 2'd0) begin errors++; $display("FAIL alu_drain_count dut%0d got %0d want 0", i, cnt[i]); end
         if (wen[i] !== 1'b0) begin errors++; $display("FAIL alu_drain_wen dut%0d got %b want 0", i, wen[i]); end
      end
   endtask

   task automatic test_load_ext();
      logic [1:0]  modes [4];
      logic [15:0] want  [4];
      modes = '{2'b10, 2'b01, 2'b11, 2'b00};
      want  = '{16'hFFF0, 16'h00F0, 16'h0080, 16'h80F0};
      for (int t = 0; t < 4; t++) begin
         idle();
         in_valid = 1; in_sel_mem = 1; in_ld_mode = modes[t];
         in_mem = 16'h80F0; in_alu = 16'hDEAD; in_rd = 3'd5;
         tick();
         in_valid = 0;
         checks++;
         if (wdata[0] !== want[t])
            begin errors++; $display("FAIL ld_mode%b got %h want %h", modes[t], wdata[0], want[t]); end
         wr_ack = 1;
         tick();
      end
   endtask

   task automatic test_full_stall();
      idle();
      set_push(3'd1, 16'h0011); tick();
      set_push(3'd1, 16'h0022); tick();
      in_valid = 0; q_addr = 3'd1; #1;
      checks += 5;
      if (cnt[0] !== 2'd2) begin errors++; $display("FAIL full_count got %0d want 2", cnt[0]); end
      if (rdy[0] !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", rdy[0]); end
      if (qhit[0] !== 1'b1) begin errors++; $display("FAIL full_qhit got %b want 1", qhit[0]); end
      if (qdata[0] !== 16'h0022) begin errors++; $display("FAIL full_qdata got %h want 0022", qdata[0]); end
      q_addr = 3'd2; #1;
      if (qhit[0] !== 1'b0) begin errors++; $display("FAIL full_qmiss got %b want 0", qhit[0]); end
      set_push(3'd2, 16'h0033); tick();
      checks += 2;
      if (cnt[0] !== 2'd2) begin errors++; $display("FAIL stall_count got %0d want 2", cnt[0]); end
      if (wdata[0] !== 16'h0011) begin errors++; $display("FAIL stall_head got %h want 0011", wdata[0]); end
      wr_ack = 1; tick();
      checks += 2;
      if (cnt[0] !== 2'd1) begin errors++; $display("FAIL fullpop_count got %0d want 1", cnt[0]); end
      if (wdata[0] !== 16'h0022) begin errors++; $display("FAIL fullpop_head got %h want 0022", wdata[0]); end
      wr_ack = 0; tick();
      in_valid = 0; wr_ack = 1;
      checks += 2;
      if (cnt[0] !== 2'd2) begin errors++; $display("FAIL repush_count got %0d want 2", cnt[0]); end
      if (wdata[0] !== 16'h0022) begin errors++; $display("FAIL order_1 got %h want 0022", wdata[0]); end
      tick();
      checks += 2;
      if (wdata[0] !== 16'h0033) begin errors++; $display("FAIL order_2 got %h want 0033", wdata[0]); end
      if (waddr[0] !== 3'd2) begin errors++; $display("FAIL order_2_addr got %h want 2", waddr[0]); end
      tick();
      checks++;
      if (cnt[0] !== 2'd0) begin errors++; $display("FAIL order_empty got %0d want 0", cnt[0]); end
   endtask

   task automatic test_zero_drop();
      idle();
      set_push(3'd0, 16'h0055); tick();
      checks += 3;
      if (cnt[1] !== 2'd0) begin errors++; $display("FAIL zd_rd0_count got %0d want 0", cnt[1]); end
      if (cnt[0] !== 2'd1) begin errors++; $display("FAIL nozd_rd0_count got %0d want 1", cnt[0]); end
      if (wdata[0] !== 16'h0055) begin errors++; $display("FAIL nozd_rd0_data got %h want 0055", wdata[0]); end
      set_push(3'd4, 16'h0044); in_reg_write = 0; tick();
      in_valid = 0;
      checks += 3;
      if (cnt[1] !== 2'd0) begin errors++; $display("FAIL nowrite_count1 got %0d want 0", cnt[1]); end
      if (cnt[0] !== 2'd1) begin errors++; $display("FAIL nowrite_count0 got %0d want 1", cnt[0]); end
      if (rdy[1] !== 1'b1) begin errors++; $display("FAIL nowrite_ready got %b want 1", rdy[1]); end
      wr_ack = 1; tick();
   endtask

   task automatic test_flush_reset();
      idle();
      set_push(3'd6, 16'h0066); tick();
      set_push(3'd7, 16'h0077); tick();
      set_push(3'd5, 16'h0088); flush = 1; wr_ack = 1; tick();
      flush = 0; in_valid = 0; wr_ack = 0; q_addr = 3'd6; #1;
      for (int i = 0; i < 2; i++) begin
         checks += 4;
         if (cnt[i] !== 2'd0) begin errors++; $display("FAIL flush_count dut%0d got %0d want 0", i, cnt[i]); end
         if (wen[i] !== 1'b0) begin errors++; $display("FAIL flush_wen dut%0d got %b want 0", i, wen[i]); end
         if (wdata[i] !== '0) begin errors++; $display("FAIL flush_wdata dut%0d got %h want 0", i, wdata[i]); end
         if (qhit[i] !== 1'b0) begin errors++; $display("FAIL flush_qhit dut%0d got %b want 0", i, qhit[i]); end
      end
      tick();
      checks++;
      if (wen[0] !== 1'b0) begin errors++; $display("FAIL flush_idle_wen got %b want 0", wen[0]); end
      set_push(3'd2, 16'h0099); tick();
      checks += 2;
      if (wen[0] !== 1'b1) begin errors++; $display("FAIL postflush_wen got %b want 1", wen[0]); end
      if (wdata[0] !== 16'h0099) begin errors++; $display("FAIL postflush_data got %h want 0099", wdata[0]); end
      set_push(3'd3, 16'h00AA); tick();
      in_valid = 0; wr_ack = 1; reset_n = 0; tick();
      q_addr = 3'd2; #1;
      for (int i = 0; i < 2; i++) begin
         checks += 6;
         if (wen[i] !== 1'b0) begin errors++; $display("FAIL rstmid_wen dut%0d got %b want 0", i, wen[i]); end
         if (waddr[i] !== '0) begin errors++; $display("FAIL rstmid_waddr dut%0d got %h want 0", i, waddr[i]); end
         if (wdata[i] !== '0) begin errors++; $display("FAIL rstmid_wdata dut%0d got %h want 0", i, wdata[i]); end
         if (qhit[i] !== 1'b0 || qdata[i] !== '0)
            begin errors++; $display("FAIL rstmid_q dut%0d got %b/%h want 0/0", i, qhit[i], qdata[i]); end
         if (cnt[i] !== 2'd0) begin errors++; $display("FAIL rstmid_count dut%0d got %0d want 0", i, cnt[i]); end
         if (rdy[i] !== 1'b1) begin errors++; $display("FAIL rstmid_ready dut%0d got %b want 1", i, rdy[i]); end
      end
      reset_n = 1; tick();
   endtask

   task automatic test_random();
      bit            e_hit;
      logic [DW-1:0] e_qd, e_wd;
      logic [AW-1:0] e_wa;
      for (int n = 0; n < 400; n++) begin
         reset_n      = ($urandom_range(0, 49) != 0);
         flush        = ($urandom_range(0, 15) == 0);
         in_valid     = $urandom_range(0, 1);
         in_reg_write = ($urandom_range(0, 3) != 0);
         in_sel_mem   = $urandom_range(0, 1);
         in_ld_mode   = 2'($urandom_range(0, 3));
         in_alu       = 16'($urandom);
         in_mem       = 16'($urandom);
         in_rd        = 3'($urandom_range(0, 7));
         wr_ack       = $urandom_range(0, 1);
         q_addr       = 3'($urandom_range(0, 7));
         #1;
         for (int i = 0; i < 2; i++) begin
            e_hit = 0; e_qd = '0;
            for (int k = 0; k < m_cnt[i]; k++)
               if (m_addr[i][k] == q_addr) begin e_hit = 1; e_qd = m_data[i][k]; end
            e_wa = (m_cnt[i] > 0) ? m_addr[i][0] : '0;
            e_wd = (m_cnt[i] > 0) ? m_data[i][0] : '0;
            checks += 7;
            if (cnt[i] !== 2'(m_cnt[i])) begin errors++; $display("FAIL rnd_count dut%0d n%0d got %0d want %0d", i, n, cnt[i], m_cnt[i]); end
            if (rdy[i] !== (m_cnt[i] < DEP)) begin errors++; $display("FAIL rnd_ready dut%0d n%0d got %b", i, n, rdy[i]); end
            if (wen[i] !== (m_cnt[i] > 0)) begin errors++; $display("FAIL rnd_wen dut%0d n%0d got %b", i, n, wen[i]); end
            if (waddr[i] !== e_wa) begin errors++; $display("FAIL rnd_waddr dut%0d n%0d got %h want %h", i, n, waddr[i], e_wa); end
            if (wdata[i] !== e_wd) begin errors++; $display("FAIL rnd_wdata dut%0d n%0d got %h want %h", i, n, wdata[i], e_wd); end
            if (qhit[i] !== e_hit) begin errors++; $display("FAIL rnd_qhit dut%0d n%0d got %b want %b", i, n, qhit[i], e_hit); end
            if (qdata[i] !== e_qd) begin errors++; $display("FAIL rnd_qdata dut%0d n%0d got %h want %h", i, n, qdata[i], e_qd); end
         end
         tick();
      end
      reset_n = 1; idle(); tick();
   endtask

   initial begin
      reset_n = 0;
      idle();
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      @(negedge clk);
      test_reset();
      test_alu_write();
      test_load_ext();
      test_full_stall();
      test_zero_drop();
      test_flush_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
